// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock. A borrow-in register extends the
// half-subtractor cell. Result and final borrow are registered and qualified by a done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    count_q, count_d;
    logic             borrow_reg_q, borrow_reg_d;
    logic             borrow_q, borrow_d;

    logic bit_x, bit_y, bit_c;
    logic bit_d, bit_bout;
    logic last_bit;

    // One full-subtractor step on the current LSBs and the stored borrow.
    always_comb begin
        bit_x    = sa_q[0];
        bit_y    = sb_q[0];
        bit_c    = borrow_reg_q;
        bit_d    = bit_x ^ bit_y ^ bit_c;
        bit_bout = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & bit_c);
        last_bit = (count_q == LAST_COUNT);
    end

    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        sd_d         = sd_q;
        diff_d       = diff_q;
        count_d      = count_q;
        borrow_reg_d = borrow_reg_q;
        borrow_d     = borrow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d         = a;
                    sb_d         = b;
                    borrow_reg_d = 1'b0;
                    count_d      = '0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                sa_d              = sa_q >> 1;
                sb_d              = sb_q >> 1;
                sd_d              = sd_q >> 1;
                sd_d[WIDTH-1]     = bit_d;
                borrow_reg_d      = bit_bout;
                count_d           = count_q + CW'(1);
                // Result registers move only on the edge that enters DONE.
                if (last_bit) begin
                    diff_d   = sd_d;
                    borrow_d = bit_bout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            sd_q         <= '0;
            diff_q       <= '0;
            count_q      <= '0;
            borrow_reg_q <= 1'b0;
            borrow_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            sd_q         <= sd_d;
            diff_q       <= diff_d;
            count_q      <= count_d;
            borrow_reg_q <= borrow_reg_d;
            borrow_q     <= borrow_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit and a 1-bit instance share clock and reset.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, busy8, done8, borrow8;
    logic [7:0] a8, b8, diff8;
    logic       start1, busy1, done1, borrow1;
    logic [0:0] a1, b1, diff1;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;

    logic [7:0] held_diff8;
    logic       held_borrow8;
    logic [0:0] held_diff1;
    logic       held_borrow1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, ncyc);
        end
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every done pulse.
    initial begin
        exp_t e;
        held_diff8 = '0; held_borrow8 = 1'b0;
        held_diff1 = '0; held_borrow1 = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                held_diff8 = '0; held_borrow8 = 1'b0;
                held_diff1 = '0; held_borrow1 = 1'b0;
            end
            if (done8 === 1'b1) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done8: got done=1 expected no done at cycle %0d", ncyc);
                end else begin
                    e = q8.pop_front();
                    chk("diff8", 32'(diff8), 32'(e.diff));
                    chk("borrow8", 32'(borrow8), 32'(e.borrow));
                    chk("latency8", 32'(ncyc), 32'(e.cyc));
                end
                held_diff8 = diff8; held_borrow8 = borrow8;
            end else begin
                chk("hold_diff8", 32'(diff8), 32'(held_diff8));
                chk("hold_borrow8", 32'(borrow8), 32'(held_borrow8));
            end
            if (done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done1: got done=1 expected no done at cycle %0d", ncyc);
                end else begin
                    e = q1.pop_front();
                    chk("diff1", 32'(diff1), 32'(e.diff));
                    chk("borrow1", 32'(borrow1), 32'(e.borrow));
                    chk("latency1", 32'(ncyc), 32'(e.cyc));
                end
                held_diff1 = diff1; held_borrow1 = borrow1;
            end else begin
                chk("hold_diff1", 32'(diff1), 32'(held_diff1));
                chk("hold_borrow1", 32'(borrow1), 32'(held_borrow1));
            end
        end
    end

    // Called 1ns after a falling edge with the 8-bit DUT idle; returns one cycle later.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eb, input bit push);
        exp_t e;
        start8 = 1'b1; a8 = a; b8 = b;
        e.diff = ed; e.borrow = eb; e.cyc = ncyc + 9;
        if (push) q8.push_back(e);
        $display("op8 a=0x%02h b=0x%02h expect diff=0x%02h borrow=%0d", a, b, ed, eb);
        @(negedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic issue1(input logic a, input logic b, input logic ed, input logic eb);
        exp_t e;
        start1 = 1'b1; a1 = a; b1 = b;
        e.diff = {7'b0, ed}; e.borrow = eb; e.cyc = ncyc + 2;
        q1.push_back(e);
        $display("op1 a=%0d b=%0d expect diff=%0d borrow=%0d", a, b, ed, eb);
        @(negedge clk); #1;
        start1 = 1'b0;
        a1 = ~a; b1 = ~b;
    endtask

    task automatic wait_idle8(output int busy_cnt);
        int n = 0;
        busy_cnt = 0;
        while (busy8 && n < 40) begin
            busy_cnt++;
            @(negedge clk); #1;
            n++;
        end
        if (busy8) begin
            checks++; errors++;
            $display("FAIL timeout_idle8: got busy=1 expected idle within 40 cycles");
        end
    endtask

    task automatic wait_idle1();
        int n = 0;
        while (busy1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (busy1) begin
            checks++; errors++;
            $display("FAIL timeout_idle1: got busy=1 expected idle within 20 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         bc;
        logic [7:0] ra, rb, rd;
        rst_n = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy8", 32'(busy8), 0);
        chk("reset_done8", 32'(done8), 0);
        chk("reset_diff8", 32'(diff8), 0);
        chk("reset_borrow8", 32'(borrow8), 0);
        chk("reset_busy1", 32'(busy1), 0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Basic op with busy-length check.
        issue8(8'h05, 8'h03, 8'h02, 1'b0, 1'b1);
        wait_idle8(bc);
        chk("busy_cycles8", 32'(bc), 9);

        issue8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b1); wait_idle8(bc);
        issue8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b1); wait_idle8(bc);
        issue8(8'h00, 8'h00, 8'h00, 1'b0, 1'b1); wait_idle8(bc);

        // Start re-pulsed while busy must be ignored.
        issue8(8'h80, 8'h7F, 8'h01, 1'b0, 1'b1);
        @(negedge clk); #1;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        @(negedge clk); #1;
        start8 = 1'b0;
        wait_idle8(bc);
        repeat (12) @(negedge clk);
        #1;

        // Reset in the middle of SHIFT (count 4) aborts with no done.
        issue8(8'hAA, 8'h55, 8'h55, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy8", 32'(busy8), 0);
        chk("abort_done8", 32'(done8), 0);
        chk("abort_diff8", 32'(diff8), 0);
        chk("abort_borrow8", 32'(borrow8), 0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        issue8(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1); wait_idle8(bc);

        // WIDTH=1 truth table.
        issue1(1'b0, 1'b0, 1'b0, 1'b0); wait_idle1();
        issue1(1'b0, 1'b1, 1'b1, 1'b1); wait_idle1();
        issue1(1'b1, 1'b0, 1'b1, 1'b0); wait_idle1();
        issue1(1'b1, 1'b1, 1'b0, 1'b0); wait_idle1();

        // Back-to-back random ops, each started at the first IDLE cycle.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rd = ra - rb;
            issue8(ra, rb, rd, (ra < rb), 1'b1);
            wait_idle8(bc);
        end

        repeat (15) @(negedge clk);
        #1;
        chk("scoreboard8_empty", 32'(q8.size()), 0);
        chk("scoreboard1_empty", 32'(q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
